// File: rtl/ieee_div_pkg.sv
// Shared types and helpers for the streaming IEEE-754 divider: operand
// classification and the sideband record that travels alongside each quotient.
package ieee_div_pkg;

  localparam int unsigned MaxTagWidth = 16;

  typedef enum logic [2:0] {
    ZERO,
    SUBNORM,
    NORMAL,
    INF,
    QNAN,
    SNAN
  } ieee_class_e;

  typedef struct packed {
    logic [MaxTagWidth-1:0] tag;
    logic                   dz;
    logic                   nv;
  } div_side_t;

  function automatic int unsigned exp_width(input int unsigned width);
    case (width)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

  // Operands narrower than 64 bits are passed zero-extended.
  function automatic ieee_class_e classify(input logic [63:0] bits, input int unsigned width);
    int unsigned ew;
    int unsigned mw;
    logic [63:0] expo;
    logic [63:0] frac;
    ew   = exp_width(width);
    mw   = width - 1 - ew;
    expo = (bits >> mw) & ((64'd1 << ew) - 64'd1);
    frac = bits & ((64'd1 << mw) - 64'd1);
    if (expo == 64'd0) return (frac == 64'd0) ? ZERO : SUBNORM;
    if (expo == ((64'd1 << ew) - 64'd1)) begin
      if (frac == 64'd0) return INF;
      return bits[mw-1] ? QNAN : SNAN;
    end
    return NORMAL;
  endfunction

  function automatic logic is_nan(input ieee_class_e c);
    return (c == QNAN) || (c == SNAN);
  endfunction

  function automatic logic is_finite_nonzero(input ieee_class_e c);
    return (c == NORMAL) || (c == SUBNORM);
  endfunction

endpackage

// File: rtl/IEEEDiv.sv
// Fixed-latency IEEE divide path: unpack/normalise, correctly rounded
// (nearest-even) quotient with gradual underflow, then a Latency-deep pipe.
module IEEEDiv
  import ieee_div_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Latency   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] x_i,
  input  logic [DataWidth-1:0] y_i,
  output logic [DataWidth-1:0] r_o
);

  localparam int unsigned EW   = exp_width(DataWidth);
  localparam int unsigned MW   = DataWidth - 1 - EW;
  localparam int          Bias = (1 << (EW - 1)) - 1;
  localparam int          EMax = (1 << EW) - 1;
  localparam int unsigned LzW  = $clog2(MW + 2);
  localparam int unsigned NumW = 2 * MW + 3;

  if (Latency < 1) begin : g_badLatency
    $error("IEEEDiv needs Latency >= 1");
  end

  function automatic logic [LzW-1:0] lzc(input logic [MW:0] m);
    lzc = LzW'(MW + 1);
    for (int i = 0; i <= MW; i++)
      if (m[i]) lzc = LzW'(MW - i);
  endfunction

  ieee_class_e          clsX, clsY;
  logic                 signQ;
  logic [MW:0]          manX, manY, normX, normY;
  logic [LzW-1:0]       lzX, lzY;
  int                   expX, expY, expQ, shAmt;
  logic [NumW-1:0]      num, den, quo, rem;
  logic [MW+2:0]        qNorm;
  logic [MW:0]          sig;
  logic                 guardB, stickyB, roundUp;
  logic [MW+1:0]        subVal, lostMask;
  logic [DataWidth-2:0] word;
  logic [DataWidth-1:0] res_d;
  logic [DataWidth-1:0] pipe_q [Latency];

  always_comb begin
    clsX  = classify(64'(x_i), DataWidth);
    clsY  = classify(64'(y_i), DataWidth);
    signQ = x_i[DataWidth-1] ^ y_i[DataWidth-1];
    manX  = {x_i[DataWidth-2:MW] != '0, x_i[MW-1:0]};
    manY  = {y_i[DataWidth-2:MW] != '0, y_i[MW-1:0]};
    lzX   = lzc(manX);
    lzY   = lzc(manY);
    normX = manX << lzX;
    normY = manY << lzY;
    expX  = ((x_i[DataWidth-2:MW] == '0) ? 1 : int'(x_i[DataWidth-2:MW])) - int'(lzX);
    expY  = ((y_i[DataWidth-2:MW] == '0) ? 1 : int'(y_i[DataWidth-2:MW])) - int'(lzY);

    // Both significands sit in [1,2), so the quotient lands in (1/2,2).
    num     = {normX, (MW + 2)'(0)};
    den     = (normY == '0) ? NumW'(1) : NumW'(normY);
    quo     = num / den;
    rem     = num % den;
    qNorm   = quo[MW+2] ? quo[MW+2:0] : {quo[MW+1:0], 1'b0};
    sig     = qNorm[MW+2:2];
    guardB  = qNorm[1];
    stickyB = qNorm[0] | (rem != '0);
    expQ    = expX - expY + Bias - (quo[MW+2] ? 0 : 1);

    roundUp  = 1'b0;
    word     = '0;
    subVal   = '0;
    lostMask = '0;
    shAmt    = 0;
    if (expQ >= EMax) begin
      word = {EW'(EMax), MW'(0)};
    end else if (expQ >= 1) begin
      word    = {EW'(expQ), sig[MW-1:0]};
      roundUp = guardB & (stickyB | sig[0]);
    end else begin
      shAmt = 1 - expQ;
      if (shAmt >= int'(MW + 2)) begin
        stickyB = stickyB | (|{sig, guardB});
      end else begin
        lostMask = ~({(MW + 2){1'b1}} << shAmt);
        stickyB  = stickyB | (|({sig, guardB} & lostMask));
        subVal   = {sig, guardB} >> shAmt;
      end
      word    = {EW'(0), subVal[MW:1]};
      roundUp = subVal[0] & (stickyB | subVal[1]);
    end

    // Rounding carry may ripple into the exponent, reaching inf or min-normal.
    if (is_nan(clsX) || is_nan(clsY) || (clsX == ZERO && clsY == ZERO) ||
        (clsX == INF && clsY == INF)) begin
      res_d = {1'b0, {EW{1'b1}}, 1'b1, (MW - 1)'(0)};
    end else if (clsX == INF || clsY == ZERO) begin
      res_d = {signQ, {EW{1'b1}}, MW'(0)};
    end else if (clsX == ZERO || clsY == INF) begin
      res_d = {signQ, (DataWidth - 1)'(0)};
    end else begin
      res_d = {signQ, word + (DataWidth - 1)'(roundUp)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Latency; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= res_d;
      for (int i = 1; i < Latency; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign r_o = pipe_q[Latency-1];

endmodule

// File: rtl/ieee_div_stream_fifo.sv
// Show-ahead synchronous FIFO; the head entry is always visible on rd_data_o.
module ieee_div_stream_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_badDepth
    $error("FIFO depth must be a power of two and at least 2");
  end

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             doWr, doRd;

  assign full_o    = (cnt_q == CntW'(Depth));
  assign empty_o   = (cnt_q == '0);
  assign doWr      = wr_en_i && !full_o;
  assign doRd      = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rdPtr_q];

  // Pointers wrap for free because Depth is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (doWr) wrPtr_d = wrPtr_q + 1'b1;
    if (doRd) rdPtr_d = rdPtr_q + 1'b1;
    if (doWr && !doRd) cnt_d = cnt_q + 1'b1;
    else if (doRd && !doWr) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doWr) mem_q[wrPtr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ieee_div_stream.sv
// Streaming IEEE divider: credit-admitted requests flow through the fixed
// latency divide path with tag/flags alongside, landing in an output FIFO.
module ieee_div_stream
  import ieee_div_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Latency   = 2,
  parameter int unsigned TagWidth  = 4,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_a_i,
  input  logic [DataWidth-1:0] in_b_i,
  input  logic [TagWidth-1:0]  in_tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_res_o,
  output logic [TagWidth-1:0]  out_tag_o,
  output logic                 out_dz_o,
  output logic                 out_nv_o
);

  localparam int unsigned OccW   = $clog2(FifoDepth + 1);
  localparam int unsigned SideW  = $bits(div_side_t);
  localparam int unsigned EntryW = DataWidth + SideW;

  if (FifoDepth < Latency + 1) begin : g_depthTooSmall
    $error("FifoDepth must be at least Latency+1");
  end
  if (TagWidth > MaxTagWidth) begin : g_tagTooWide
    $error("TagWidth exceeds MaxTagWidth");
  end

  ieee_class_e          clsA, clsB;
  div_side_t            sideIn;
  div_side_t            side_q [Latency];
  logic [Latency-1:0]   vld_q;
  logic [OccW-1:0]      occ_q, occ_d;
  logic                 accept, pop;
  logic [DataWidth-1:0] divRes;
  logic [EntryW-1:0]    fifoWrData, fifoRdData;
  logic                 fifoWr, fifoFull, fifoEmpty;
  div_side_t            headSide;

  assign in_ready_o = !rst_i && (occ_q < OccW'(FifoDepth));
  assign accept     = in_valid_i && in_ready_o;
  assign pop        = out_valid_o && out_ready_i;

  always_comb begin
    clsA       = classify(64'(in_a_i), DataWidth);
    clsB       = classify(64'(in_b_i), DataWidth);
    sideIn.tag = MaxTagWidth'(in_tag_i);
    sideIn.dz  = (clsB == ZERO) && is_finite_nonzero(clsA);
    sideIn.nv  = is_nan(clsA) || is_nan(clsB) || (clsA == ZERO && clsB == ZERO) ||
                 (clsA == INF && clsB == INF);
  end

  // Credits cover in-flight plus buffered results, so the FIFO cannot overflow.
  always_comb begin
    occ_d = occ_q;
    if (accept && !pop) occ_d = occ_q + 1'b1;
    else if (pop && !accept) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < Latency; i++) side_q[i] <= '0;
    end else begin
      occ_q     <= occ_d;
      vld_q[0]  <= accept;
      side_q[0] <= sideIn;
      for (int i = 1; i < Latency; i++) begin
        vld_q[i]  <= vld_q[i-1];
        side_q[i] <= side_q[i-1];
      end
      assert (!(fifoWr && fifoFull));
    end
  end

  IEEEDiv #(
    .DataWidth(DataWidth),
    .Latency  (Latency)
  ) u_div (
    .clk_i (clk_i),
    .rst_ni(~rst_i),
    .x_i   (in_a_i),
    .y_i   (in_b_i),
    .r_o   (divRes)
  );

  assign fifoWr     = vld_q[Latency-1];
  assign fifoWrData = {divRes, side_q[Latency-1]};

  ieee_div_stream_fifo #(
    .Width(EntryW),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (fifoWr),
    .wr_data_i(fifoWrData),
    .rd_en_i  (pop),
    .rd_data_o(fifoRdData),
    .full_o   (fifoFull),
    .empty_o  (fifoEmpty)
  );

  // Outputs read as zero whenever nothing is buffered.
  assign headSide    = div_side_t'(fifoRdData[SideW-1:0]);
  assign out_valid_o = !fifoEmpty;
  assign out_res_o   = fifoEmpty ? '0 : fifoRdData[EntryW-1 -: DataWidth];
  assign out_tag_o   = fifoEmpty ? '0 : headSide.tag[TagWidth-1:0];
  assign out_dz_o    = !fifoEmpty && headSide.dz;
  assign out_nv_o    = !fifoEmpty && headSide.nv;

endmodule

// File: tb/tb_ieee_div_stream.sv
// Directed bench for ieee_div_stream: latency, exceptions, backpressure,
// back-to-back streaming and mid-stream reset, with an in-order scoreboard.
module tb_ieee_div_stream;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned Latency   = 2;
  localparam int unsigned TagWidth  = 4;
  localparam int unsigned FifoDepth = 4;
  localparam int          NumVec    = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inA = '0;
  logic [31:0] inB = '0;
  logic [3:0]  inTag = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] outRes;
  logic [3:0]  outTag;
  logic        outDz, outNv;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        dz;
    logic        nv;
  } exp_t;

  exp_t expQ[$];
  exp_t curExp;
  int   total = 0;
  int   bad = 0;
  int   stalls = 0;
  logic lastAccept = 1'b0;

  // a, b, expected quotient, dz, nv (nv rows expect a NaN quotient)
  logic [31:0] vecA [NumVec] = '{32'h40C00000, 32'h3F800000, 32'h41200000, 32'hC0800000,
                                 32'h3F800000, 32'h00000001, 32'h7F7FFFFF, 32'h00800000,
                                 32'h7F800000, 32'h40000000, 32'hC0000000, 32'h7F800001};
  logic [31:0] vecB [NumVec] = '{32'h40000000, 32'h40000000, 32'h40A00000, 32'h40000000,
                                 32'h40400000, 32'h3F800000, 32'h3F000000, 32'h40000000,
                                 32'h40000000, 32'hFF800000, 32'h80000000, 32'h3F800000};
  logic [31:0] vecR [NumVec] = '{32'h40400000, 32'h3F000000, 32'h40000000, 32'hC0000000,
                                 32'h3EAAAAAB, 32'h00000001, 32'h7F800000, 32'h00400000,
                                 32'h7F800000, 32'h80000000, 32'h7F800000, 32'h7FC00000};
  logic        vecDz [NumVec] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic        vecNv [NumVec] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  ieee_div_stream #(
    .DataWidth(DataWidth),
    .Latency  (Latency),
    .TagWidth (TagWidth),
    .FifoDepth(FifoDepth)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .in_a_i     (inA),
    .in_b_i     (inB),
    .in_tag_i   (inTag),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .out_res_o  (outRes),
    .out_tag_o  (outTag),
    .out_dz_o   (outDz),
    .out_nv_o   (outNv)
  );

  function automatic logic isNan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                               input logic [31:0] r, input logic dz, input logic nv);
    inValid = 1'b1;
    inA     = a;
    inB     = b;
    inTag   = tag;
    curExp  = '{res: r, tag: tag, dz: dz, nv: nv};
  endtask

  task automatic applyVec(input int k, input logic [3:0] tag);
    applyStimulus(vecA[k], vecB[k], tag, vecR[k], vecDz[k], vecNv[k]);
  endtask

  // Judges the handshakes the coming posedge will see, then waits a cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (outValid && outReady) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousResult", 1, 0);
      end else begin
        e = expQ.pop_front();
        if (e.nv) checkOutput("resIsNan", isNan(outRes), 1);
        else checkOutput("res", outRes, e.res);
        checkOutput("tag", outTag, e.tag);
        checkOutput("dz", outDz, e.dz);
        checkOutput("nv", outNv, e.nv);
      end
    end
    lastAccept = inValid && inReady;
    if (lastAccept) expQ.push_back(curExp);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("drainLeft", expQ.size(), 0);
  endtask

  task automatic runSingle(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                           input logic dz, input logic nv, input logic [3:0] tag);
    applyStimulus(a, b, tag, r, dz, nv);
    tick();
    checkOutput("singleAccept", lastAccept, 1);
    inValid = 1'b0;
    drain();
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int accepted;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstReady", inReady, 0);
    checkOutput("rstValid", outValid, 0);
    checkOutput("rstRes", outRes, 0);
    checkOutput("rstTag", outTag, 0);
    checkOutput("rstDz", outDz, 0);
    checkOutput("rstNv", outNv, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("readyAfterRst", inReady, 1);

    $display("[TB] single op latency");
    outReady = 1'b1;
    applyStimulus(32'h40C00000, 32'h40000000, 4'd5, 32'h40400000, 1'b0, 1'b0);
    tick();
    checkOutput("latAccept", lastAccept, 1);
    inValid = 1'b0;
    cnt = 1;
    while (!outValid && cnt < 20) begin
      tick();
      cnt++;
    end
    checkOutput("latency", cnt, 3);
    drain();

    $display("[TB] exception cases");
    runSingle(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 4'd1);
    runSingle(32'h00000000, 32'h80000000, 32'h7FC00000, 1'b0, 1'b1, 4'd2);
    runSingle(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b1, 4'd3);
    runSingle(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 4'd4);

    $display("[TB] backpressure");
    outReady = 1'b0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      applyVec(k, 4'(8 + k));
      tick();
      if (lastAccept) accepted++;
      if (k == 2) checkOutput("readyBefore4th", inReady, 1);
      if (k == 3) checkOutput("readyFallAfter4th", inReady, 0);
    end
    checkOutput("bpAccepted", accepted, 4);
    inValid = 1'b0;
    repeat (3) tick();
    checkOutput("bpValid", outValid, 1);
    checkOutput("bpReadyLow", inReady, 0);
    outReady = 1'b1;
    tick();
    checkOutput("readyAfterPop", inReady, 1);
    drain();

    $display("[TB] streaming");
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      applyVec((i * 5) % NumVec, 4'(i % 16));
      tick();
      cnt = 0;
      while (!lastAccept && cnt < 10) begin
        stalls++;
        tick();
        cnt++;
      end
    end
    inValid = 1'b0;
    drain();
    checkOutput("stalls", stalls, 0);

    $display("[TB] reset mid-stream");
    outReady = 1'b0;
    for (int k = 0; k < 2; k++) begin
      applyVec(k, 4'(k));
      tick();
    end
    inValid = 1'b0;
    repeat (2) tick();
    for (int k = 2; k < 4; k++) begin
      applyVec(k, 4'(k));
      tick();
    end
    inValid = 1'b0;
    checkOutput("preRstValid", outValid, 1);
    rst = 1'b1;
    #1;
    checkOutput("midRstReady", inReady, 0);
    tick();
    rst = 1'b0;
    expQ.delete();
    checkOutput("postRstValid", outValid, 0);
    checkOutput("postRstOcc", dut.occ_q, 0);
    outReady = 1'b1;
    repeat (5) begin
      tick();
      checkOutput("postRstQuiet", outValid, 0);
    end
    runSingle(vecA[4], vecB[4], vecR[4], vecDz[4], vecNv[4], 4'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
